// File: rtl/wb_stage.sv
// Writeback stage: merges the ALU result path and the buffered memory/MDU
// result path into a single registered register-file write port.
//
// The ALU path has fixed priority and no backpressure. Memory results are
// held in a small FIFO; the FIFO head retires only in cycles where the ALU
// is idle. All outputs except mem_ready are registered.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   alu_valid, alu_*             ALU result (always accepted)
//   mem_valid, mem_ready, mem_*  memory result handshake into the FIFO
//   rf_we, rf_waddr, rf_wdata    register-file write port
//   wb_valid                     one instruction retired this cycle
//   debug_wb_pc, debug_wb_inst   last retired PC / instruction
//   instret                      retired-instruction counter
module wb_stage #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic        alu_rd_we,
  input  logic [63:0] alu_data,
  input  logic [63:0] alu_pc,
  input  logic [31:0] alu_inst,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic        mem_rd_we,
  input  logic [63:0] mem_data,
  input  logic [63:0] mem_pc,
  input  logic [31:0] mem_inst,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        wb_valid,
  output logic [63:0] debug_wb_pc,
  output logic [31:0] debug_wb_inst,
  output logic [63:0] instret
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic [63:0] pc;
    logic [31:0] inst;
  } wb_entry_t;

  wb_entry_t      fifo_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  wb_entry_t      mem_entry;
  wb_entry_t      sel_entry;
  logic           sel_valid;
  logic           push, pop;

  logic           rf_we_q, rf_we_d;
  logic [4:0]     rf_waddr_q, rf_waddr_d;
  logic [63:0]    rf_wdata_q, rf_wdata_d;
  logic           wb_valid_q, wb_valid_d;
  logic [63:0]    dbg_pc_q, dbg_pc_d;
  logic [31:0]    dbg_inst_q, dbg_inst_d;
  logic [63:0]    instret_q, instret_d;

  assign mem_entry = '{rd: mem_rd, we: mem_rd_we, data: mem_data, pc: mem_pc, inst: mem_inst};

  // Ready comes only from registered occupancy, so a pop in a full cycle
  // cannot open room for a push in that same cycle.
  assign mem_ready = (count_q < CW'(FIFO_DEPTH));
  assign push      = mem_valid & mem_ready;
  assign pop       = ~alu_valid & (count_q != '0);

  // Fixed-priority select: ALU first, then FIFO head.
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_entry = '{rd: alu_rd, we: alu_rd_we, data: alu_data, pc: alu_pc, inst: alu_inst};
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_entry = fifo_q[rd_ptr_q];
    end
  end

  // Pointer wrap relies on FIFO_DEPTH being a power of two.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    wb_valid_d = sel_valid;
    rf_we_d    = sel_valid & sel_entry.we & (sel_entry.rd != 5'd0);
    rf_waddr_d = sel_valid ? sel_entry.rd   : rf_waddr_q;
    rf_wdata_d = sel_valid ? sel_entry.data : rf_wdata_q;
    dbg_pc_d   = sel_valid ? sel_entry.pc   : dbg_pc_q;
    dbg_inst_d = sel_valid ? sel_entry.inst : dbg_inst_q;
    instret_d  = instret_q + 64'(sel_valid);
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= mem_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_valid_q <= 1'b0;
      dbg_pc_q   <= '0;
      dbg_inst_q <= '0;
      instret_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      wb_valid_q <= wb_valid_d;
      dbg_pc_q   <= dbg_pc_d;
      dbg_inst_q <= dbg_inst_d;
      instret_q  <= instret_d;
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign wb_valid      = wb_valid_q;
  assign debug_wb_pc   = dbg_pc_q;
  assign debug_wb_inst = dbg_inst_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, a mid-operation
// reset sequence, and randomized traffic checked against a queue-based model.
module tb_wb_stage;

  localparam int unsigned Depth = 2;
  localparam logic [31:0] AluInst = 32'h0000_0013;
  localparam logic [31:0] MemInst = 32'h0000_3003;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic        alu_rd_we;
  logic [63:0] alu_data;
  logic [63:0] alu_pc;
  logic [31:0] alu_inst;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic        mem_rd_we;
  logic [63:0] mem_data;
  logic [63:0] mem_pc;
  logic [31:0] mem_inst;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        wb_valid;
  logic [63:0] debug_wb_pc;
  logic [31:0] debug_wb_inst;
  logic [63:0] instret;

  wb_stage #(.FIFO_DEPTH(Depth)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_rd_we    (alu_rd_we),
    .alu_data     (alu_data),
    .alu_pc       (alu_pc),
    .alu_inst     (alu_inst),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_rd_we    (mem_rd_we),
    .mem_data     (mem_data),
    .mem_pc       (mem_pc),
    .mem_inst     (mem_inst),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .wb_valid     (wb_valid),
    .debug_wb_pc  (debug_wb_pc),
    .debug_wb_inst(debug_wb_inst),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic        m_wb, m_we;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata, m_pc, m_instret;
  logic [31:0] m_inst;

  task automatic model_reset();
    q.delete();
    m_wb = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_pc = 0; m_inst = 0; m_instret = 0;
  endtask

  // Effect of one rising edge given the inputs currently driven.
  task automatic model_step();
    ent_t s;
    bit   sel;
    bit   room;
    room = (q.size() < Depth);
    sel  = 1'b0;
    if (alu_valid) begin
      s = '{rd: alu_rd, we: alu_rd_we, data: alu_data, pc: alu_pc, inst: alu_inst};
      sel = 1'b1;
    end else if (q.size() > 0) begin
      s = q.pop_front();
      sel = 1'b1;
    end
    if (mem_valid && room)
      q.push_back('{rd: mem_rd, we: mem_rd_we, data: mem_data, pc: mem_pc, inst: mem_inst});
    m_wb = sel;
    m_we = sel && s.we && (s.rd != 0);
    if (sel) begin
      m_waddr = s.rd; m_wdata = s.data; m_pc = s.pc; m_inst = s.inst;
      m_instret = m_instret + 1;
    end
  endtask

  task automatic check_model();
    chk("model wb_valid", 64'(wb_valid), 64'(m_wb));
    chk("model rf_we", 64'(rf_we), 64'(m_we));
    chk("model rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    chk("model rf_wdata", rf_wdata, m_wdata);
    chk("model debug_wb_pc", debug_wb_pc, m_pc);
    chk("model debug_wb_inst", 64'(debug_wb_inst), 64'(m_inst));
    chk("model instret", instret, m_instret);
    chk("model mem_ready", 64'(mem_ready), 64'(q.size() < Depth));
  endtask

  task automatic cycle(input bit use_model);
    model_step();
    @(posedge clk);
    #1;
    if (use_model) check_model();
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_rd_we = 0; alu_data = 0; alu_pc = 0; alu_inst = AluInst;
    mem_valid = 0; mem_rd = 0; mem_rd_we = 0; mem_data = 0; mem_pc = 0; mem_inst = MemInst;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic        awe;
    logic [63:0] adata;
    logic [63:0] apc;
    logic        mv;
    logic [4:0]  mrd;
    logic [63:0] mdata;
    logic        ewb;
    logic        ewe;
    logic [4:0]  ewaddr;
    logic [63:0] ewdata;
    logic [63:0] einstret;
    logic [63:0] epc;
    logic        erdy;
  } vec_t;

  function automatic vec_t mk(logic av, logic [4:0] ard, logic awe, logic [63:0] adata,
                              logic [63:0] apc, logic mv, logic [4:0] mrd, logic [63:0] mdata,
                              logic ewb, logic ewe, logic [4:0] ewaddr, logic [63:0] ewdata,
                              logic [63:0] einstret, logic [63:0] epc, logic erdy);
    vec_t v;
    v = '{av, ard, awe, adata, apc, mv, mrd, mdata, ewb, ewe, ewaddr, ewdata, einstret, epc, erdy};
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    string tag;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    // Memory pc is 0x2000 + 4*rd throughout the table.
    vecs[0]  = mk(1, 5, 1, 'h1234, 'h100,      0, 0, 0,      1, 1, 5, 'h1234, 1, 'h100, 1);
    vecs[1]  = mk(1, 0, 1, 'h55,   'h80000000, 0, 0, 0,      1, 0, 0, 'h55, 2, 'h80000000, 1);
    vecs[2]  = mk(0, 0, 0, 0,      0,          0, 0, 0,      0, 0, 0, 'h55, 2, 'h80000000, 1);
    vecs[3]  = mk(0, 0, 0, 0,      0,          1, 7, 'hAB,   0, 0, 0, 'h55, 2, 'h80000000, 1);
    vecs[4]  = mk(0, 0, 0, 0,      0,          0, 0, 0,      1, 1, 7, 'hAB, 3, 'h201C, 1);
    vecs[5]  = mk(1, 1, 1, 'h11,   'h104,      1, 8, 'h88,   1, 1, 1, 'h11, 4, 'h104, 1);
    vecs[6]  = mk(1, 2, 1, 'h22,   'h108,      1, 9, 'h99,   1, 1, 2, 'h22, 5, 'h108, 0);
    vecs[7]  = mk(1, 3, 1, 'h33,   'h10C,      1, 10, 'hAA,  1, 1, 3, 'h33, 6, 'h10C, 0);
    vecs[8]  = mk(0, 0, 0, 0,      0,          0, 0, 0,      1, 1, 8, 'h88, 7, 'h2020, 1);
    vecs[9]  = mk(0, 0, 0, 0,      0,          0, 0, 0,      1, 1, 9, 'h99, 8, 'h2024, 1);
    vecs[10] = mk(0, 0, 0, 0,      0,          0, 0, 0,      0, 0, 9, 'h99, 8, 'h2024, 1);
    vecs[11] = mk(1, 4, 0, 'h44,   'h110,      1, 11, 'hB1,  1, 0, 4, 'h44, 9, 'h110, 1);
    vecs[12] = mk(1, 4, 1, 'h45,   'h114,      1, 12, 'hB2,  1, 1, 4, 'h45, 10, 'h114, 0);
    vecs[13] = mk(0, 0, 0, 0,      0,          1, 13, 'hB3,  1, 1, 11, 'hB1, 11, 'h202C, 1);
    vecs[14] = mk(0, 0, 0, 0,      0,          1, 13, 'hB3,  1, 1, 12, 'hB2, 12, 'h2030, 1);
    vecs[15] = mk(0, 0, 0, 0,      0,          0, 0, 0,      1, 1, 13, 'hB3, 13, 'h2034, 1);
    vecs[16] = mk(0, 0, 0, 0,      0,          0, 0, 0,      0, 0, 13, 'hB3, 13, 'h2034, 1);

    // Reset state
    #12;
    chk("reset wb_valid", 64'(wb_valid), 0);
    chk("reset rf_we", 64'(rf_we), 0);
    chk("reset rf_waddr", 64'(rf_waddr), 0);
    chk("reset rf_wdata", rf_wdata, 0);
    chk("reset debug_wb_pc", debug_wb_pc, 0);
    chk("reset debug_wb_inst", 64'(debug_wb_inst), 0);
    chk("reset instret", instret, 0);
    chk("reset mem_ready", 64'(mem_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      alu_valid = vecs[i].av;  alu_rd = vecs[i].ard; alu_rd_we = vecs[i].awe;
      alu_data  = vecs[i].adata; alu_pc = vecs[i].apc;
      mem_valid = vecs[i].mv;  mem_rd = vecs[i].mrd; mem_rd_we = 1'b1;
      mem_data  = vecs[i].mdata; mem_pc = 64'h2000 + 64'(vecs[i].mrd) * 4;
      cycle(0);
      tag = $sformatf("vec%0d", i);
      chk({tag, " wb_valid"}, 64'(wb_valid), 64'(vecs[i].ewb));
      chk({tag, " rf_we"}, 64'(rf_we), 64'(vecs[i].ewe));
      chk({tag, " rf_waddr"}, 64'(rf_waddr), 64'(vecs[i].ewaddr));
      chk({tag, " rf_wdata"}, rf_wdata, vecs[i].ewdata);
      chk({tag, " instret"}, instret, vecs[i].einstret);
      chk({tag, " debug_wb_pc"}, debug_wb_pc, vecs[i].epc);
      chk({tag, " mem_ready"}, 64'(mem_ready), 64'(vecs[i].erdy));
    end

    // Mid-operation reset with two entries buffered behind a busy ALU.
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1; alu_rd = 5'd20; alu_rd_we = 1; alu_data = 64'hDEAD; alu_pc = 64'h300;
      mem_valid = 1; mem_rd = 5'(21 + i); mem_rd_we = 1; mem_data = 64'hBEEF0 + 64'(i);
      mem_pc = 64'h400;
      cycle(1);
    end
    idle_inputs();
    chk("pre-reset mem_ready", 64'(mem_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst wb_valid", 64'(wb_valid), 0);
    chk("async rst rf_we", 64'(rf_we), 0);
    chk("async rst rf_waddr", 64'(rf_waddr), 0);
    chk("async rst rf_wdata", rf_wdata, 0);
    chk("async rst debug_wb_pc", debug_wb_pc, 0);
    chk("async rst instret", instret, 0);
    chk("async rst mem_ready", 64'(mem_ready), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1);
      chk("post-reset no write", 64'(rf_we | wb_valid), 0);
    end

    // Randomized traffic: ALU-heavy first half fills the FIFO, lighter second half drains it.
    for (int i = 0; i < 400; i++) begin
      alu_valid = ($urandom_range(0, 99) < ((i < 200) ? 70 : 20));
      alu_rd    = 5'($urandom_range(0, 31));
      alu_rd_we = 1'($urandom);
      alu_data  = {$urandom, $urandom};
      alu_pc    = {$urandom, $urandom};
      alu_inst  = $urandom;
      if (!(mem_valid && !mem_ready)) begin
        mem_valid = ($urandom_range(0, 99) < 60);
        mem_rd    = 5'($urandom_range(0, 31));
        mem_rd_we = 1'($urandom);
        mem_data  = {$urandom, $urandom};
        mem_pc    = {$urandom, $urandom};
        mem_inst  = $urandom;
      end
      cycle(1);
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) cycle(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, depth of the memory-result buffer; legal values are powers of two, 2 or more.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have port alu_valid, input, 1, ALU result present this cycle; always accepted, with no ready signal.
REQ-005 SHALL have ports alu_rd (input, 5), alu_rd_we (input, 1), alu_data (input, 64), alu_pc (input, 64) and alu_inst (input, 32): the ALU destination, write enable, result, PC and instruction.
REQ-006 SHALL have port mem_valid, input, 1, load/MDU result offered.
REQ-007 SHALL have port mem_ready, output, 1, buffer can accept.
REQ-008 SHALL have ports mem_rd (input, 5), mem_rd_we (input, 1), mem_data (input, 64), mem_pc (input, 64) and mem_inst (input, 32): the same fields as the ALU path, for the memory path.
REQ-009 SHALL have port rf_we, output, 1, register-file write enable.
REQ-010 SHALL have port rf_waddr, output, 5, register-file write address.
REQ-011 SHALL have port rf_wdata, output, 64, register-file write data.
REQ-012 SHALL have port wb_valid, output, 1, one instruction retires this cycle.
REQ-013 SHALL have ports debug_wb_pc (output, 64) and debug_wb_inst (output, 32), the last retired PC and instruction.
REQ-014 SHALL have port instret, output, 64, count of retired instructions.

Function
REQ-015 Memory-path handshake SHALL complete when mem_valid and mem_ready are both 1 in the same cycle; the entry is written to the FIFO at that edge.
REQ-016 mem_ready SHALL be 1 exactly when FIFO occupancy < FIFO_DEPTH, and SHALL depend only on registered occupancy.
REQ-017 Arbitration SHALL give fixed priority to the ALU:
- alu_valid=1: the ALU entry is selected.
- Otherwise, FIFO non-empty: the FIFO head is selected and popped.
- Otherwise: nothing is selected.
REQ-018 Push and pop in the same cycle SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH; the FIFO SHALL be strictly first-in first-out.
REQ-019 All outputs other than mem_ready SHALL be registered. A selection in cycle N SHALL appear at the outputs in cycle N+1:
- ALU latency 1.
- Memory latency 2 minimum: handshake in N, pop at earliest N+1, visible N+2.
REQ-020 wb_valid SHALL be 1 for exactly one cycle per selected entry and 0 when nothing is selected.
REQ-021 rf_we SHALL be (selected rd_we and rd != 0) and SHALL be 0 whenever wb_valid=0.
REQ-022 rf_waddr and rf_wdata SHALL load the selected rd and data on every selection, and hold otherwise.
REQ-023 A retirement with rd=0 or rd_we=0 SHALL still assert wb_valid, update debug_wb_pc/debug_wb_inst and increment instret.
REQ-024 debug_wb_pc and debug_wb_inst SHALL update only on selection and hold between retirements.
REQ-025 instret SHALL increment by 1 on each wb_valid cycle and wrap from 2^64-1 to 0.
REQ-026 With the FIFO full and mem_valid=1, no push SHALL occur and the entry SHALL be held by the producer. A pop in that cycle SHALL not enable a same-cycle push.
REQ-027 Sustained alu_valid=1 SHALL starve the FIFO; no fairness is required.

Reset
REQ-028 rst_n=0 SHALL asynchronously force the following, regardless of clk:
- FIFO empty, so mem_ready=1.
- rf_we=0, wb_valid=0.
- rf_waddr=0, rf_wdata=0.
- debug_wb_pc=0, debug_wb_inst=0.
- instret=0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries and any registered retirement; nothing buffered SHALL be written after release.
REQ-030 After rst_n deasserts, inputs SHALL be sampled from the first rising edge.

Verification
REQ-031 ALU write: alu_valid=1, rd=5, we=1, data=0x1234 in cycle N -> in N+1: rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_valid=1, instret=1.
REQ-032 Memory latency: single mem handshake rd=7, data=0xAB in cycle N, ALU idle -> rf_we=1, rf_waddr=7 in N+2.
REQ-033 Contention: alu_valid=1 for 3 cycles while 2 mem handshakes occur -> 3 ALU writebacks, then mem entries in order, with mem_ready=0 once 2 entries are held (FIFO_DEPTH=2).
REQ-034 x0 write: ALU rd=0, we=1, pc=0x80000000 -> rf_we=0, wb_valid=1, debug_wb_pc=0x80000000, instret incremented.
REQ-035 Full plus simultaneous: FIFO full, mem_valid=1, ALU idle -> one pop, no push that cycle, mem_ready=1 next cycle, accepted entry retires after the older one.
REQ-036 Reset mid-operation: 2 entries buffered, rst_n pulsed low between edges -> outputs 0 immediately, mem_ready=1, no write of buffered data afterwards.
